qspim_shifter: RTL and testbench
================================

# qspim_shifter

Data-path stage directly downstream of `qspim_clkgen` in the QSPI master. It consumes the `spi_fall` / `spi_rise` / `spi_clk_idle` pulses and drives `en` back into the clock generator. It serialises 32-bit transmit words onto 1, 2 or 4 IO lanes and deserialises receive lanes into 32-bit words. Transfers are bit-counted; the shifter stalls the SPI clock at word boundaries when its word-stream partner is not ready.

## Interface
Parameters: none (word width fixed at 32, length counter fixed at 16 bits).

Ports:
- `clk`  in  1  system clock; the same clock as `qspim_clkgen`.
- `rstn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle command pulse; sampled only in IDLE.
- `cfg_mode`  in  2  lane mode: 0 = single, 1 = dual, 2 = quad, 3 = reserved (treated as single). Latched at `start`.
- `cfg_dir`  in  1  1 = transmit, 0 = receive. Latched at `start`.
- `cfg_len`  in  16  transfer length in bits; a multiple of the lane count. Latched at `start`.
- `spi_fall`, `spi_rise`, `spi_clk_idle`  in  1  from `qspim_clkgen`.
- `clk_en`  out  1  drives `qspim_clkgen.en`.
- `tx_data`  in  32  transmit word, MSB first.
- `tx_valid`  in  1  transmit word handshake.
- `tx_ready`  out  1  transmit word handshake.
- `rx_data`  out  32  receive word.
- `rx_valid`  out  1  receive word handshake.
- `rx_ready`  in  1  receive word handshake.
- `sdi`  in  4  IO lane inputs.
- `sdo`  out  4  IO lane outputs.
- `sdo_oe`  out  4  IO lane output enables.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse at the end of a transfer.

## Operation
- Lanes per edge (L): single = 1, dual = 2, quad = 4.
- FSM states: IDLE, LOAD, SHIFT, STALL, DRAIN.
- IDLE
  - On `start`: latch the config; `bit_cnt` ← `cfg_len`.
  - `cfg_len` = 0 → go to DRAIN with no clocks.
  - Otherwise → go to LOAD.
  - `start` in any other state is ignored.
- LOAD
  - Transmit: assert `tx_ready`, wait for `tx_valid`. Handshake → shift register ← `tx_data`, `word_cnt` ← 32, go to SHIFT.
  - Receive: clear the shift register, `word_cnt` ← 32, go to SHIFT immediately.
- SHIFT (`clk_en` = 1)
  - Transmit, on `spi_fall`: `sdo` lanes ← shift[31 -: L], then shift left by L.
  - Receive, on `spi_rise`: shift left by L, inserting `sdi[1]` (single), `sdi[1:0]` (dual) or `sdi[3:0]` (quad).
  - On each `spi_rise`: `bit_cnt` −= L and `word_cnt` −= L.
  - At that rise, `bit_cnt` reaching 0 → DRAIN.
  - Otherwise `word_cnt` reaching 0 → STALL.
- STALL (`clk_en` = 0)
  - Transmit: `tx_ready` = 1. Handshake → reload the shift register, `word_cnt` ← 32, go to SHIFT.
  - Receive: present the full word with `rx_valid` = 1. Handshake → `word_cnt` ← 32, go to SHIFT.
- DRAIN (`clk_en` = 0)
  - Receive with a residual partial word (`word_cnt` ≠ 32, nonzero bits captured): present it right-aligned and wait for `rx_ready`.
  - Then wait for `spi_clk_idle` = 1, pulse `done` for one cycle, go to IDLE.
- `sdo_oe`
  - Transmit: lanes [L-1:0] are 1 for the whole of SHIFT and STALL.
  - Receive: 0.
  - Single-lane transmit drives `sdo[0]` only.
- `rx_valid` holds, with `rx_data` stable, until `rx_ready`. `rx_data` keeps its last value otherwise.
- Arithmetic: `bit_cnt` and `word_cnt` are unsigned and never wrap; reaching 0 is the terminal event. A non-multiple `cfg_len` is illegal; behaviour is then defined only as terminating when `bit_cnt` < L.

## Timing
- Reset values: `clk_en` 0, `sdo` 0, `sdo_oe` 0, `tx_ready` 0, `rx_valid` 0, `rx_data` 0, `busy` 0, `done` 0. FSM in IDLE.
- Reset asserted mid-transfer: immediate return to IDLE with reset values. No `done` is issued.
- `busy` rises in the cycle after `start`.
- `clk_en` and `sdo` are registered.
  - `sdo` updates in the same cycle as `qspim_clkgen` drives `spi_clk` low, so data changes on the falling edge and is stable at the rising edge.
- `clk_en` drops in the cycle after the last `spi_rise` of a word or transfer, so no further `spi_fall` is issued (`qspim_clkgen` parks `spi_clk` high).
- Handshake completes when valid && ready are both high on a `clk` edge. `tx_ready` is high only in LOAD and STALL.
- Simultaneous events: `bit_cnt` = 0 and `word_cnt` = 0 at the same rise → DRAIN, never STALL.
- `done` fires no earlier than the cycle after `spi_clk_idle` is seen high in DRAIN.

## Structure
- `qspim_pkg` holds:
  - `qspim_mode_e` (SINGLE, DUAL, QUAD)
  - `qspim_dir_e`
  - the FSM state enum
  - constants `QSPIM_WORD_W` = 32 and `QSPIM_LEN_W` = 16.
- One sub-module: `qspim_shift_reg`. It holds the 32-bit register with load, shift-out and shift-in by L, and the `word_cnt` counter. The FSM and handshakes stay in `qspim_shifter`.

## Test plan
- **Single transmit:** `cfg_len` = 8, `tx_data` = 0xA5000000 → `sdo[0]` = 1,0,1,0,0,1,0,1 on 8 consecutive falls, `sdo_oe` = 0001, `done` after `spi_clk_idle`.
- **Quad receive:** `cfg_len` = 32, `sdi` nibbles 1..8 on successive rises → `rx_data` = 0x12345678, `rx_valid` held until `rx_ready`.
- **Dual transmit stall:** `cfg_len` = 64, second `tx_valid` delayed 20 cycles → `clk_en` drops after the 16th rise, no extra `spi_fall`, resumes with word 2 MSB lanes.
- **Receive backpressure with partial tail:** `cfg_len` = 40 single, `rx_ready` low for 10 cycles after word 1 → clock stalls, then a tail word with 8 right-aligned bits.
- **Zero length:** `cfg_len` = 0 → no `spi_fall`, `tx_ready` never asserted, `done` pulses.
- **Reset mid-transfer:** `rstn` pulsed low mid-SHIFT → all outputs at reset values, no `done`. A following `start` works normally.

Source files
------------

// File: rtl/qspim_pkg.sv
// Shared types and constants for the QSPI master data path.
// Lane mode, direction and shifter FSM state encodings.
package qspim_pkg;

  localparam int QSPIM_WORD_W = 32;
  localparam int QSPIM_LEN_W  = 16;
  localparam int QSPIM_CNT_W  = 6;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DUAL   = 2'd1,
    MODE_QUAD   = 2'd2
  } qspim_mode_e;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } qspim_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STALL,
    ST_DRAIN
  } qspim_state_e;

  function automatic logic [2:0] lanes_of(qspim_mode_e m);
    case (m)
      MODE_DUAL: return 3'd2;
      MODE_QUAD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] oe_mask(qspim_mode_e m);
    case (m)
      MODE_DUAL: return 4'b0011;
      MODE_QUAD: return 4'b1111;
      default:   return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/qspim_shift_reg.sv
// 32-bit lane shift register with parallel load/clear and the per-word bit counter.
// Receive data enters at the LSB, so a partial word is already right-aligned.
module qspim_shift_reg
  import qspim_pkg::*;
(
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          load_i,
  input  logic [QSPIM_WORD_W-1:0]       load_data_i,
  input  logic                          clear_i,
  input  logic                          shift_out_i,
  input  logic                          shift_in_i,
  input  logic                          count_i,
  input  qspim_mode_e                   mode_i,
  input  logic [3:0]                    sdi_i,
  output logic [QSPIM_WORD_W-1:0]       data_o,
  output logic [3:0]                    lanes_o,
  output logic [QSPIM_CNT_W-1:0]        word_cnt_o,
  output logic                          word_last_o
);

  logic [QSPIM_WORD_W-1:0] sr_q, sr_d;
  logic [QSPIM_CNT_W-1:0]  cnt_q, cnt_d;
  logic [QSPIM_CNT_W-1:0]  step;

  assign step        = {3'b000, lanes_of(mode_i)};
  assign word_last_o = (cnt_q <= step);
  assign word_cnt_o  = cnt_q;
  assign data_o      = sr_q;

  always_comb begin
    case (mode_i)
      MODE_DUAL: lanes_o = {2'b00, sr_q[31:30]};
      MODE_QUAD: lanes_o = sr_q[31:28];
      default:   lanes_o = {3'b000, sr_q[31]};
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_out_i) begin
      case (mode_i)
        MODE_DUAL: sr_d = {sr_q[29:0], 2'b00};
        MODE_QUAD: sr_d = {sr_q[27:0], 4'b0000};
        default:   sr_d = {sr_q[30:0], 1'b0};
      endcase
    end else if (shift_in_i) begin
      // Single-lane receive takes MISO from IO1.
      case (mode_i)
        MODE_DUAL: sr_d = {sr_q[29:0], sdi_i[1:0]};
        MODE_QUAD: sr_d = {sr_q[27:0], sdi_i[3:0]};
        default:   sr_d = {sr_q[30:0], sdi_i[1]};
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || load_i) begin
      cnt_d = QSPIM_CNT_W'(QSPIM_WORD_W);
    end else if (count_i) begin
      cnt_d = word_last_o ? '0 : cnt_q - step;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= QSPIM_CNT_W'(QSPIM_WORD_W);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/qspim_shifter.sv
// QSPI master shifter: serialises/deserialises 32-bit words on 1/2/4 lanes and
// gates the SPI clock generator at word boundaries when the stream partner stalls.
module qspim_shifter
  import qspim_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_dir,
  input  logic [QSPIM_LEN_W-1:0]  cfg_len,
  input  logic                    spi_fall,
  input  logic                    spi_rise,
  input  logic                    spi_clk_idle,
  output logic                    clk_en,
  input  logic [QSPIM_WORD_W-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [QSPIM_WORD_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  input  logic [3:0]              sdi,
  output logic [3:0]              sdo,
  output logic [3:0]              sdo_oe,
  output logic                    busy,
  output logic                    done
);

  qspim_state_e            state_q, state_d;
  qspim_mode_e             mode_q, mode_d;
  qspim_dir_e              dir_q, dir_d;
  logic [QSPIM_LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                    clk_en_q, clk_en_d;
  logic [3:0]              sdo_q, sdo_d;
  logic [QSPIM_WORD_W-1:0] rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    done_q, done_d;

  logic                    sr_load, sr_clear, sr_shout, sr_shin, sr_count;
  logic [QSPIM_WORD_W-1:0] sr_data;
  logic [3:0]              sr_lanes;
  logic [QSPIM_CNT_W-1:0]  word_cnt;
  logic                    word_last;
  logic                    bit_last;
  logic                    is_tx;

  qspim_shift_reg u_sr (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (sr_load),
    .load_data_i (tx_data),
    .clear_i     (sr_clear),
    .shift_out_i (sr_shout),
    .shift_in_i  (sr_shin),
    .count_i     (sr_count),
    .mode_i      (mode_q),
    .sdi_i       (sdi),
    .data_o      (sr_data),
    .lanes_o     (sr_lanes),
    .word_cnt_o  (word_cnt),
    .word_last_o (word_last)
  );

  // Saturating compare also terminates an illegal non-multiple length.
  assign bit_last = (bit_cnt_q <= {13'd0, lanes_of(mode_q)});
  assign is_tx    = (dir_q == DIR_TX);

  assign clk_en   = clk_en_q;
  assign sdo      = sdo_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign sdo_oe   = (is_tx && (state_q == ST_SHIFT || state_q == ST_STALL)) ? oe_mask(mode_q) : 4'b0000;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    bit_cnt_d  = bit_cnt_q;
    sdo_d      = sdo_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;
    tx_ready   = 1'b0;
    sr_load    = 1'b0;
    sr_clear   = 1'b0;
    sr_shout   = 1'b0;
    sr_shin    = 1'b0;
    sr_count   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = (cfg_mode == 2'd3) ? MODE_SINGLE : qspim_mode_e'(cfg_mode);
          dir_d     = qspim_dir_e'(cfg_dir);
          bit_cnt_d = cfg_len;
          sr_clear  = 1'b1;
          state_d   = (cfg_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (is_tx) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            sr_load = 1'b1;
            state_d = ST_SHIFT;
          end
        end else begin
          sr_clear = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (is_tx && spi_fall) begin
          sdo_d    = sr_lanes;
          sr_shout = 1'b1;
        end
        if (spi_rise) begin
          sr_count  = 1'b1;
          sr_shin   = !is_tx;
          bit_cnt_d = bit_last ? '0 : bit_cnt_q - {13'd0, lanes_of(mode_q)};
          if (bit_last) begin
            state_d = ST_DRAIN;
          end else if (word_last) begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (is_tx) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            sr_load = 1'b1;
            state_d = ST_SHIFT;
          end
        end else if (!rx_valid_q) begin
          rx_data_d  = sr_data;
          rx_valid_d = 1'b1;
        end else if (rx_ready) begin
          rx_valid_d = 1'b0;
          sr_clear   = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        // A receive tail is flushed before waiting for the clock to park.
        if (!is_tx && word_cnt != QSPIM_CNT_W'(QSPIM_WORD_W)) begin
          if (!rx_valid_q) begin
            rx_data_d  = sr_data;
            rx_valid_d = 1'b1;
          end else if (rx_ready) begin
            rx_valid_d = 1'b0;
            sr_clear   = 1'b1;
          end
        end else if (spi_clk_idle) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clk_en_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_SINGLE;
      dir_q      <= DIR_RX;
      bit_cnt_q  <= '0;
      clk_en_q   <= 1'b0;
      sdo_q      <= 4'b0000;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_en_q   <= clk_en_d;
      sdo_q      <= sdo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_qspim_shifter.sv
// Directed bench for qspim_shifter with a small behavioural clock-generator model.
module tb_qspim_shifter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        cfg_dir = 1'b0;
  logic [15:0] cfg_len = 16'd0;
  logic        spi_fall, spi_rise, spi_clk_idle;
  logic        clk_en;
  logic [31:0] tx_data = 32'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  sdi = 4'd0;
  logic [3:0]  sdo, sdo_oe;
  logic        busy, done;

  qspim_shifter dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .cfg_mode     (cfg_mode),
    .cfg_dir      (cfg_dir),
    .cfg_len      (cfg_len),
    .spi_fall     (spi_fall),
    .spi_rise     (spi_rise),
    .spi_clk_idle (spi_clk_idle),
    .clk_en       (clk_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .sdi          (sdi),
    .sdo          (sdo),
    .sdo_oe       (sdo_oe),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Clock generator model: spi_clk idles high, toggles every 2 clk cycles while enabled.
  logic spi_clk, div_q;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_clk      <= 1'b1;
      div_q        <= 1'b0;
      spi_fall     <= 1'b0;
      spi_rise     <= 1'b0;
      spi_clk_idle <= 1'b0;
    end else begin
      spi_fall     <= 1'b0;
      spi_rise     <= 1'b0;
      spi_clk_idle <= !clk_en && spi_clk;
      if (!clk_en) begin
        div_q   <= 1'b0;
        spi_clk <= 1'b1;
      end else if (div_q) begin
        div_q    <= 1'b0;
        spi_clk  <= ~spi_clk;
        spi_fall <= spi_clk;
        spi_rise <= ~spi_clk;
      end else begin
        div_q <= 1'b1;
      end
    end
  end

  int         nfall = 0;
  int         done_cnt = 0;
  bit         txr_seen = 1'b0;
  logic [3:0] oe_seen = 4'd0;
  logic [3:0] sdo_log[$];
  logic [3:0] sdi_q[$];

  always @(negedge clk) begin
    if (spi_fall) begin
      nfall++;
      if (sdi_q.size() > 0) sdi = sdi_q.pop_front();
    end
    if (spi_rise) begin
      sdo_log.push_back(sdo);
      oe_seen = sdo_oe;
    end
    if (done) done_cnt++;
    if (tx_ready) txr_seen = 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic begin_xfer(input logic [1:0] m, input logic d, input logic [15:0] len);
    @(negedge clk);
    cfg_mode = m;
    cfg_dir  = d;
    cfg_len  = len;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [31:0] w);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_txrdy"}, {31'd0, tx_ready}, 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (!rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rxvld"}, {31'd0, rx_valid}, 32'd1);
  endtask

  task automatic take_rx();
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] pack_log(input int lanes_n, input int first, input int count);
    logic [31:0] w = 32'd0;
    logic [3:0]  mask = 4'((1 << lanes_n) - 1);
    for (int i = first; i < first + count && i < sdo_log.size(); i++)
      w = (w << lanes_n) | {28'd0, sdo_log[i] & mask};
    return w;
  endfunction

  function automatic logic [31:0] ctl_vec();
    return {19'd0, clk_en, sdo, sdo_oe, tx_ready, rx_valid, busy, done};
  endfunction

  initial begin
    int         nf0, nf1, done0, n;
    logic [3:0] acc;
    logic [31:0] w1, w2;

    repeat (3) @(negedge clk);
    check_eq("rst_ctl", ctl_vec(), 32'd0);
    check_eq("rst_rxdata", rx_data, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single-lane transmit of one byte.
    sdo_log.delete();
    nf0 = nfall; done0 = done_cnt;
    begin_xfer(2'd0, 1'b1, 16'd8);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    send_word("t1", 32'hA500_0000);
    wait_done("t1");
    @(negedge clk);
    check_eq("t1_nbits", 32'(sdo_log.size()), 32'd8);
    check_eq("t1_bits", pack_log(1, 0, 8), 32'h0000_00A5);
    acc = 4'd0;
    foreach (sdo_log[i]) acc = acc | sdo_log[i];
    check_eq("t1_upper_lanes", {28'd0, acc & 4'hE}, 32'd0);
    check_eq("t1_falls", 32'(nfall - nf0), 32'd8);
    check_eq("t1_oe", {28'd0, oe_seen}, 32'h1);
    check_eq("t1_done_cnt", 32'(done_cnt - done0), 32'd1);
    check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

    // Quad receive of one full word, held under backpressure.
    for (int i = 1; i <= 8; i++) sdi_q.push_back(4'(i));
    done0 = done_cnt;
    begin_xfer(2'd2, 1'b0, 16'd32);
    wait_rx("t2");
    check_eq("t2_data", rx_data, 32'h1234_5678);
    repeat (5) @(negedge clk);
    check_eq("t2_hold", {31'd0, rx_valid}, 32'd1);
    check_eq("t2_stable", rx_data, 32'h1234_5678);
    check_eq("t2_nodone", 32'(done_cnt - done0), 32'd0);
    check_eq("t2_oe", {28'd0, oe_seen}, 32'd0);
    take_rx();
    wait_done("t2");
    @(negedge clk);
    check_eq("t2_vld_end", {31'd0, rx_valid}, 32'd0);
    check_eq("t2_data_keep", rx_data, 32'h1234_5678);

    // Dual transmit of two words with a late second word.
    sdo_log.delete();
    nf0 = nfall;
    begin_xfer(2'd1, 1'b1, 16'd64);
    send_word("t3a", 32'h9ABC_DEF0);
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_stall_rdy", {31'd0, tx_ready}, 32'd1);
    nf1 = nfall;
    repeat (20) @(negedge clk);
    check_eq("t3_nofall", 32'(nfall - nf1), 32'd0);
    check_eq("t3_falls_w1", 32'(nfall - nf0), 32'd16);
    check_eq("t3_clken_low", {31'd0, clk_en}, 32'd0);
    check_eq("t3_nbits_w1", 32'(sdo_log.size()), 32'd16);
    send_word("t3b", 32'h5A5A_C3C3);
    wait_done("t3");
    check_eq("t3_nbits", 32'(sdo_log.size()), 32'd32);
    check_eq("t3_word1", pack_log(2, 0, 16), 32'h9ABC_DEF0);
    check_eq("t3_word2", pack_log(2, 16, 16), 32'h5A5A_C3C3);
    check_eq("t3_oe", {28'd0, oe_seen}, 32'h3);

    // Single receive, 40 bits: stalled full word then an 8-bit tail.
    w1 = 32'hF0E1_D2C3;
    w2 = 32'h0000_005A;
    for (int i = 31; i >= 0; i--) sdi_q.push_back({~w1[i], ~w1[i], w1[i], ~w1[i]});
    for (int i = 7; i >= 0; i--) sdi_q.push_back({~w2[i], ~w2[i], w2[i], ~w2[i]});
    nf0 = nfall;
    begin_xfer(2'd0, 1'b0, 16'd40);
    wait_rx("t4a");
    check_eq("t4_word1", rx_data, 32'hF0E1_D2C3);
    nf1 = nfall;
    repeat (10) @(negedge clk);
    check_eq("t4_stall_nofall", 32'(nfall - nf1), 32'd0);
    check_eq("t4_hold", {31'd0, rx_valid}, 32'd1);
    take_rx();
    wait_rx("t4b");
    check_eq("t4_tail", rx_data, 32'h0000_005A);
    take_rx();
    wait_done("t4");
    check_eq("t4_falls", 32'(nfall - nf0), 32'd40);

    // Zero-length transfer.
    @(negedge clk);
    txr_seen = 1'b0;
    nf0 = nfall; done0 = done_cnt;
    begin_xfer(2'd0, 1'b1, 16'd0);
    wait_done("t5");
    @(negedge clk);
    check_eq("t5_nofall", 32'(nfall - nf0), 32'd0);
    check_eq("t5_no_txrdy", {31'd0, txr_seen}, 32'd0);
    check_eq("t5_done_cnt", 32'(done_cnt - done0), 32'd1);
    check_eq("t5_busy_end", {31'd0, busy}, 32'd0);

    // Reset in the middle of a quad transmit, then a clean transfer.
    nf0 = nfall; done0 = done_cnt;
    begin_xfer(2'd2, 1'b1, 16'd32);
    send_word("t6", 32'hDEAD_BEEF);
    n = 0;
    while ((nfall - nf0) < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_midshift", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_eq("t6_rst_ctl", ctl_vec(), 32'd0);
    check_eq("t6_rst_rxdata", rx_data, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t6_nodone", 32'(done_cnt - done0), 32'd0);
    check_eq("t6_idle_ctl", ctl_vec(), 32'd0);

    sdo_log.delete();
    begin_xfer(2'd2, 1'b1, 16'd8);
    send_word("t7", 32'h3C00_0000);
    wait_done("t7");
    check_eq("t7_nbits", 32'(sdo_log.size()), 32'd2);
    check_eq("t7_bits", pack_log(4, 0, 2), 32'h0000_003C);
    check_eq("t7_oe", {28'd0, oe_seen}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
